// File: rtl/aes_pkg.sv
// Shared AES-128 sequencer definitions: FSM encoding, round/width constants, Rcon step.
package aes_pkg;

  localparam int         AES_NR    = 10;
  localparam int         AES_DW    = 128;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  // GF(2^8) multiply-by-x; 8'h80 wraps to 8'h1b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Rcon register for the key-expansion step: load restarts at 8'h01, advance steps by xtime.
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       advance,
  output logic [7:0] rcon
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rcon <= RCON_INIT;
    else if (load)    rcon <= RCON_INIT;
    else if (advance) rcon <= xtime(rcon);
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 sequencer: owns state/key/round/Rcon and drives an external round datapath.
// Optional abort port is built in when AES_ABORT_EN is defined.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int DW = AES_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_pt,
  input  logic [DW-1:0] in_key,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_ct,
  output logic [DW-1:0] dp_state,
  output logic [DW-1:0] dp_rkey,
  output logic          dp_last,
  input  logic [DW-1:0] dp_result,
  output logic [DW-1:0] ks_key,
  output logic [7:0]    ks_rcon,
  input  logic [DW-1:0] ks_next
`ifdef AES_ABORT_EN
  ,
  input  logic          abort
`endif
);

  localparam logic [3:0] NR_L = 4'(NR);

  aes_state_e    fsm, fsm_nxt;
  logic [DW-1:0] state_r, key_r;
  logic [3:0]    round;
  logic [7:0]    rcon;
  logic          running, accept, handshake, last_round, abort_hit;

  assign running    = (fsm == RUN);
  assign accept     = (fsm == IDLE) && in_valid;
  assign handshake  = (fsm == DONE) && out_ready;
  assign last_round = running && (round == NR_L);

`ifdef AES_ABORT_EN
  assign abort_hit = abort && (fsm != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    if (in_valid)   fsm_nxt = RUN;
      RUN:     if (last_round) fsm_nxt = DONE;
      DONE:    if (out_ready)  fsm_nxt = IDLE;
      default:                 fsm_nxt = IDLE;
    endcase
    // Abort wins over completion and over the output handshake.
    if (abort_hit) fsm_nxt = IDLE;
  end

  // Round counter saturates at NR on the final round so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= '0;
      key_r   <= '0;
      round   <= '0;
    end else if (accept) begin
      state_r <= in_pt ^ in_key;
      key_r   <= in_key;
      round   <= 4'd1;
    end else if (abort_hit || handshake) begin
      round   <= '0;
    end else if (running) begin
      state_r <= dp_result;
      key_r   <= ks_next;
      if (round != NR_L) round <= round + 4'd1;
    end
  end

  aes_rcon_gen u_rcon (
    .clk     (clk),
    .rst     (rst),
    .load    (accept | abort_hit),
    .advance (running & ~abort_hit),
    .rcon    (rcon)
  );

  always_comb begin
    in_ready  = (fsm == IDLE);
    out_valid = (fsm == DONE);
    out_ct    = (fsm == DONE) ? state_r : '0;
    dp_state  = state_r;
    dp_rkey   = running ? ks_next : key_r;
    dp_last   = last_round;
    ks_key    = key_r;
    ks_rcon   = rcon;
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: supplies a behavioural AES round/key step and checks against FIPS-197 and a reference cipher.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, dp_last;
  logic [127:0] in_pt, in_key, out_ct, dp_state, dp_rkey, dp_result, ks_key, ks_next;
  logic [7:0]   ks_rcon;
`ifdef AES_ABORT_EN
  logic         abort;
`endif

  always #5 clk = ~clk;

  logic [7:0] sbox [256];
  logic [7:0] rc_tab [10];
  localparam logic [79:0] RC_EXP = 80'h01020408102040801b36;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
    int           hold;
  } vec_t;
  vec_t vt [3];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse then affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k,
                                            input logic last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) b[r+4*c] = a[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        logic [7:0] x0, x1, x2, x3;
        x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
        b[4*c]   = gmul(x0, 2) ^ gmul(x1, 3) ^ x2 ^ x3;
        b[4*c+1] = x0 ^ gmul(x1, 2) ^ gmul(x2, 3) ^ x3;
        b[4*c+2] = x0 ^ x1 ^ gmul(x2, 2) ^ gmul(x3, 3);
        b[4*c+3] = gmul(x0, 3) ^ x1 ^ x2 ^ gmul(x3, 2);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o ^ k;
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]} ^ {rc, 24'h0};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s = pt ^ key;
    logic [127:0] k = key;
    for (int r = 1; r <= 10; r++) begin
      k = key_next(k, rc_tab[r-1]);
      s = round_fn(s, k, r == 10);
    end
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // External datapath and key step, combinational as the controller expects.
  assign ks_next   = key_next(ks_key, ks_rcon);
  assign dp_result = round_fn(dp_state, dp_rkey, dp_last);

  aes_round_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pt     (in_pt),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ct    (out_ct),
    .dp_state  (dp_state),
    .dp_rkey   (dp_rkey),
    .dp_last   (dp_last),
    .dp_result (dp_result),
    .ks_key    (ks_key),
    .ks_rcon   (ks_rcon),
    .ks_next   (ks_next)
`ifdef AES_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge with the controller idle; returns at the negedge after the accept edge.
  task automatic start_block(input logic [127:0] pt, input logic [127:0] key, input string tag);
    check({tag, " in_ready before"}, 128'(in_ready), 128'd1);
    in_pt = pt; in_key = key; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, " in_ready after accept"}, 128'(in_ready), 128'd0);
  endtask

  task automatic wait_done(input logic [127:0] exp, input string tag);
    int         cyc = 0;
    logic [79:0] rc = '0;
    logic [9:0]  lst = '0;
    while (!out_valid && cyc < 40) begin
      if (cyc < 10) begin
        rc[79-8*cyc -: 8] = ks_rcon;
        lst[cyc] = dp_last;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 128'(cyc), 128'd10);
    check({tag, " rcon seq"}, 128'(rc), {48'h0, RC_EXP});
    check({tag, " dp_last pattern"}, 128'(lst), 128'h200);
    check({tag, " out_ct"}, out_ct, exp);
  endtask

  task automatic finish_block(input int hold, input string tag);
    logic [127:0] ct0 = out_ct;
    int bad = 0;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_pt = rnd128(); in_key = rnd128();
      @(negedge clk);
      if (!out_valid || in_ready || out_ct !== ct0) bad++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (hold > 0) check({tag, " hold violations"}, 128'(bad), 128'd0);
    check({tag, " out_valid after hs"}, 128'(out_valid), 128'd0);
    check({tag, " in_ready after hs"}, 128'(in_ready), 128'd1);
  endtask

  task automatic quiet_cycles(input int n, input string tag);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check({tag, " no output"}, 128'(seen), 128'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_pt = '0; in_key = '0;
`ifdef AES_ABORT_EN
    abort = 1'b0;
`endif
    rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    vt[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0};
    vt[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
              128'h3925841d02dc09fbdc118597196a0b32, 20};
    vt[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 3};
    build_sbox();

    @(negedge clk); @(negedge clk);
    check("reset in_ready",  128'(in_ready),  128'd1);
    check("reset out_valid", 128'(out_valid), 128'd0);
    check("reset out_ct",    out_ct,          128'd0);
    check("reset dp_last",   128'(dp_last),   128'd0);
    rst = 1'b0;

    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle out_ready out_valid", 128'(out_valid), 128'd0);
    check("idle out_ready in_ready",  128'(in_ready),  128'd1);

    for (int v = 0; v < 3; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      start_block(vt[v].pt, vt[v].key, tag);
      wait_done(vt[v].ct, tag);
      finish_block(vt[v].hold, tag);
    end

    // Back-to-back: second block is held on in_valid through the first handshake.
    start_block(vt[0].pt, vt[0].key, "b2b first");
    wait_done(vt[0].ct, "b2b first");
    in_pt = vt[1].pt; in_key = vt[1].key; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b hs out_valid", 128'(out_valid), 128'd0);
    check("b2b no bypass",    128'(in_ready),  128'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b second accepted", 128'(in_ready), 128'd0);
    wait_done(vt[1].ct, "b2b second");
    finish_block(0, "b2b second");

    // Reset while round 5 is in flight.
    start_block(vt[1].pt, vt[1].key, "midrst");
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst in_ready",  128'(in_ready),  128'd1);
    check("midrst out_valid", 128'(out_valid), 128'd0);
    check("midrst out_ct",    out_ct,          128'd0);
    check("midrst dp_last",   128'(dp_last),   128'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet_cycles(15, "midrst");
    start_block(vt[0].pt, vt[0].key, "postrst");
    wait_done(vt[0].ct, "postrst");
    finish_block(1, "postrst");

    for (int n = 0; n < 8; n++) begin
      logic [127:0] pt, key;
      string tag;
      tag = $sformatf("rnd%0d", n);
      pt = rnd128(); key = rnd128();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start_block(pt, key, tag);
      wait_done(ref_encrypt(pt, key), tag);
      finish_block(int'($urandom_range(0, 4)), tag);
    end

`ifdef AES_ABORT_EN
    start_block(vt[1].pt, vt[1].key, "abort run");
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort run in_ready",  128'(in_ready),  128'd1);
    check("abort run out_valid", 128'(out_valid), 128'd0);
    quiet_cycles(15, "abort run");

    start_block(vt[0].pt, vt[0].key, "abort done");
    wait_done(vt[0].ct, "abort done");
    abort = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; out_ready = 1'b0;
    check("abort done out_valid", 128'(out_valid), 128'd0);
    check("abort done in_ready",  128'(in_ready),  128'd1);

    abort = 1'b1;
    start_block(vt[2].pt, vt[2].key, "abort idle");
    abort = 1'b0;
    wait_done(vt[2].ct, "abort idle");
    finish_block(0, "abort idle");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
